// File: rtl/seq_pkg.sv
// Shared definitions for the SEQ processor: instruction codes, status codes,
// sequencer state encoding and icode classification helpers.
package seq_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Architectural status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StPcupd,
        StHalt,
        StFault
    } state_e;

    // Instructions that touch data memory
    function automatic logic needs_mem(input logic [3:0] ic);
        return ic inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    endfunction

    // Instructions that write the register file
    function automatic logic writes_reg(input logic [3:0] ic);
        return ic inside {IRRMOVQ, IIRMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ};
    endfunction

endpackage

// File: rtl/seq_mem_timeout.sv
// Loadable down-counter bounding the time spent waiting on data memory.
// expired is high during the last permitted wait cycle (count reaches zero).
module seq_mem_timeout #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    // Load on MEMORY entry, then count down once per wait cycle, saturating at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/seq_stage_ctrl.sv
// Central stage sequencer for the SEQ processor. Walks each instruction through
// fetch/decode/execute/memory/write-back/PC-update with one-hot registered enables,
// skipping unneeded stages and producing the architectural status code.
// Optional performance counters are built when SEQ_CTRL_PERF_EN is defined.
module seq_stage_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             busy
`ifdef SEQ_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
        $error("seq_stage_ctrl: MEM_TIMEOUT and CNT_W must be at least 1");
    end

    state_e     state_q, state_d;
    logic [2:0] stat_d;
    logic [3:0] icode_q;
    logic       tmo_load;
    logic       tmo_expired;

    seq_mem_timeout #(
        .WIDTH(TMO_W)
    ) u_mem_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (tmo_load),
        .en      (state_q == StMemory),
        .load_val(TMO_W'(MEM_TIMEOUT - 1)),
        .expired (tmo_expired)
    );

    // Next-state and status decision for the current stage
    always_comb begin
        state_d  = state_q;
        stat_d   = stat;
        tmo_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (imem_error) begin
                    state_d = StFault;
                    stat_d  = SADR;
                end else if (!instr_valid || (icode > IPOPQ)) begin
                    state_d = StFault;
                    stat_d  = SINS;
                end else if (icode == IHALT) begin
                    state_d = StHalt;
                    stat_d  = SHLT;
                end else begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                if (needs_mem(icode_q)) begin
                    state_d  = StMemory;
                    tmo_load = 1'b1;
                end else if (writes_reg(icode_q)) begin
                    state_d = StWriteback;
                end else begin
                    state_d = StPcupd;
                end
            end
            StMemory: begin
                // A ready in the final permitted cycle still counts as success
                if (dmem_ready) begin
                    if (dmem_error) begin
                        state_d = StFault;
                        stat_d  = SADR;
                    end else if (writes_reg(icode_q)) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StPcupd;
                    end
                end else if (tmo_expired) begin
                    state_d = StFault;
                    stat_d  = SADR;
                end
            end
            StWriteback: begin
                state_d = StPcupd;
            end
            StPcupd: begin
                state_d = StFetch;
            end
            StHalt, StFault: begin
                state_d = state_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with enables registered from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            stat      <= SAOK;
            icode_q   <= IHALT;
            fetch_en  <= 1'b0;
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            mem_en    <= 1'b0;
            wb_en     <= 1'b0;
            pc_en     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            stat      <= stat_d;
            fetch_en  <= (state_d == StFetch);
            decode_en <= (state_d == StDecode);
            exec_en   <= (state_d == StExecute);
            mem_en    <= (state_d == StMemory);
            wb_en     <= (state_d == StWriteback);
            pc_en     <= (state_d == StPcupd);
            busy      <= !(state_d inside {StIdle, StHalt, StFault});
            // icode is only trusted during FETCH; hold it for the rest of the instruction
            if (state_q == StFetch) icode_q <= icode;
        end
    end

`ifdef SEQ_CTRL_PERF_EN
    // Busy-cycle and retired-instruction counters, wrapping at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy)  cycle_cnt <= cycle_cnt + 1'b1;
            if (pc_en) instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed scenarios plus randomized
// instruction streams checked cycle by cycle against a stage-list model.
module tb_seq_stage_ctrl;

    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned CNT_W       = 32;

    localparam logic [5:0] EN_F = 6'b100000;
    localparam logic [5:0] EN_D = 6'b010000;
    localparam logic [5:0] EN_E = 6'b001000;
    localparam logic [5:0] EN_M = 6'b000100;
    localparam logic [5:0] EN_W = 6'b000010;
    localparam logic [5:0] EN_P = 6'b000001;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] icode = 4'd0;
    logic       instr_valid = 1'b0;
    logic       imem_error = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       dmem_error = 1'b0;
    logic       fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic [2:0] stat;
    logic       busy;
`ifdef SEQ_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;
`endif

    logic [5:0] en_vec;
    assign en_vec = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en};

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cyc = '0;
    logic [CNT_W-1:0] exp_ins = '0;
    int term;

    seq_stage_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .instr_valid(instr_valid),
        .imem_error (imem_error),
        .dmem_ready (dmem_ready),
        .dmem_error (dmem_error),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .exec_en    (exec_en),
        .mem_en     (mem_en),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .stat       (stat),
        .busy       (busy)
`ifdef SEQ_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the mid-cycle point and compare all outputs
    task automatic cycle_check(input logic [5:0] exp_en, input logic exp_busy,
                               input logic [2:0] exp_stat, input string tag);
        @(negedge clk);
        check({tag, ".en"},   32'(en_vec), 32'(exp_en));
        check({tag, ".busy"}, 32'(busy),   32'(exp_busy));
        check({tag, ".stat"}, 32'(stat),   32'(exp_stat));
`ifdef SEQ_CTRL_PERF_EN
        check({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(exp_cyc));
        check({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(exp_ins));
`endif
        if (exp_busy) exp_cyc = exp_cyc + 1'b1;
        if (exp_en == EN_P) exp_ins = exp_ins + 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("rst.en",   32'(en_vec), 32'd0);
        check("rst.busy", 32'(busy),   32'd0);
        check("rst.stat", 32'(stat),   32'(S_AOK));
        @(negedge clk);
        rst = 1'b0;
        exp_cyc = '0;
        exp_ins = '0;
    endtask

    task automatic start_run();
        cycle_check(6'd0, 1'b0, S_AOK, "idle");
        start = 1'b1;
    endtask

    // Model: the list of stages an instruction visits, from the stage rules directly
    task automatic do_instr(input int ic, input bit valid, input bit ierr,
                            input int rdy_at, input bit derr, output int t);
        logic [5:0] q[$];
        int         mem_idx;
        bit         timeout;
        q.push_back(EN_F);
        t = 0;
        if (ierr)                  t = S_ADR;
        else if (!valid || ic > 11) t = S_INS;
        else if (ic == 0)          t = S_HLT;
        else begin
            q.push_back(EN_D);
            q.push_back(EN_E);
            if (ic inside {4, 5, 8, 9, 10, 11}) begin
                timeout = (rdy_at < 1) || (rdy_at > int'(MEM_TIMEOUT));
                repeat (timeout ? int'(MEM_TIMEOUT) : rdy_at) q.push_back(EN_M);
                if (timeout || derr) t = S_ADR;
            end
            if (t == 0) begin
                if (ic inside {2, 3, 5, 6, 8, 9, 10, 11}) q.push_back(EN_W);
                q.push_back(EN_P);
            end
        end
        mem_idx = 0;
        foreach (q[i]) begin
            cycle_check(q[i], 1'b1, S_AOK, $sformatf("ic%0d.step%0d", ic, i));
            start = 1'($urandom);
            if (q[i] == EN_F) begin
                icode       = 4'(ic);
                instr_valid = valid;
                imem_error  = ierr;
            end else begin
                icode       = 4'($urandom);
                instr_valid = 1'($urandom);
                imem_error  = 1'($urandom);
            end
            if (q[i] == EN_M) begin
                mem_idx++;
                dmem_ready = (mem_idx == rdy_at);
                dmem_error = (mem_idx == rdy_at) ? derr : 1'($urandom);
            end else begin
                dmem_ready = 1'($urandom);
                dmem_error = 1'($urandom);
            end
        end
        if (t != 0) begin
            for (int k = 0; k < 3; k++) begin
                cycle_check(6'd0, 1'b0, 3'(t), $sformatf("ic%0d.term%0d", ic, k));
                start = (k % 2 == 0);
            end
            start = 1'b0;
        end
    endtask

    initial begin
        // Reset and a plain ALU instruction
        do_reset();
        start_run();
        do_instr(6, 1'b1, 1'b0, 0, 1'b0, term);
        // Store with three wait cycles, no write-back
        do_instr(4, 1'b1, 1'b0, 3, 1'b0, term);
        // Random stream of non-faulting instructions
        for (int n = 0; n < 30; n++) begin
            do_instr(int'($urandom_range(1, 11)), 1'b1, 1'b0,
                     int'($urandom_range(1, 5)), 1'b0, term);
        end
        // Ready on the final permitted cycle succeeds, then halt
        do_instr(5, 1'b1, 1'b0, int'(MEM_TIMEOUT), 1'b0, term);
        do_instr(0, 1'b1, 1'b0, 0, 1'b0, term);

        // Memory timeout
        do_reset();
        start_run();
        do_instr(5, 1'b1, 1'b0, 0, 1'b0, term);
        // Illegal icode
        do_reset();
        start_run();
        do_instr(13, 1'b1, 1'b0, 0, 1'b0, term);
        // imem_error beats halt
        do_reset();
        start_run();
        do_instr(0, 1'b1, 1'b1, 0, 1'b0, term);
        // instr_valid low
        do_reset();
        start_run();
        do_instr(3, 1'b0, 1'b0, 0, 1'b0, term);
        // Data memory address error
        do_reset();
        start_run();
        do_instr(9, 1'b1, 1'b0, 2, 1'b1, term);

        // Asynchronous reset in the middle of MEMORY
        do_reset();
        start_run();
        cycle_check(EN_F, 1'b1, S_AOK, "async.f");
        start = 1'b0;
        icode = 4'd5;
        instr_valid = 1'b1;
        imem_error = 1'b0;
        dmem_ready = 1'b0;
        cycle_check(EN_D, 1'b1, S_AOK, "async.d");
        cycle_check(EN_E, 1'b1, S_AOK, "async.e");
        cycle_check(EN_M, 1'b1, S_AOK, "async.m1");
        cycle_check(EN_M, 1'b1, S_AOK, "async.m2");
        #2 rst = 1'b1;
        #1;
        check("async.en",   32'(en_vec), 32'd0);
        check("async.busy", 32'(busy),   32'd0);
        check("async.stat", 32'(stat),   32'(S_AOK));
        @(negedge clk);
        rst = 1'b0;
        exp_cyc = '0;
        exp_ins = '0;
        start_run();
        do_instr(8, 1'b1, 1'b0, 2, 1'b0, term);
        do_instr(1, 1'b1, 1'b0, 0, 1'b0, term);
        do_instr(0, 1'b1, 1'b0, 0, 1'b0, term);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
